seg7_scan_hc595: RTL
====================

// Module: seg7_scan_hc595
// PURPOSE
//  Multiplexed 7-segment display scanner feeding the 74HC595 serial driver.
//  Each refresh slot it builds one 16-bit frame (segments + one digit select).
//  It hands the frame over with a 1-cycle lock strobe and waits on the driver's busy.
//  Sits between the application registers (hex digits/masks) and the 595 driver.
// PARAMETERS
//  NUM_DIGITS     8      digits scanned, 1..8; select bits above NUM_DIGITS-1 held inactive
//  REFRESH_DIV    50000  clk cycles per digit slot (>=2)
//  BUSY_TIMEOUT   16     cycles to wait for busy rise after lock before giving up on the frame
//  SEG_ACTIVE_LOW 1      1: segment bit 0 = lit
//  DIG_ACTIVE_LOW 1      1: digit select bit 0 = enabled
// PORTS
//  clk         in   1   system clock, single clock domain
//  rst         in   1   synchronous, active-high reset
//  enable      in   1   1 = scanning; 0 = finish current transfer, then idle
//  digits      in   32  8 hex nibbles, digit i = digits[4i+3:4i]
//  dp_mask     in   8   decimal point per digit, 1 = lit
//  blank_mask  in   8   1 = digit i shows all segments off
//  busy        in   1   from 595 driver, high while shifting
//  data        out  16  frame to driver: [15:8] seg {dp,g,f,e,d,c,b,a}, [7:0] digit select
//  lock        out  1   1-cycle strobe: data valid, start transfer
//  digit_idx   out  3   digit currently (or last) sent
// BEHAVIOUR
//  Reset (rst=1 at posedge):
//   - data = OFF frame: segments and digits inactive per polarity params
//     (both polarities =1 gives 16'hFFFF)
//   - lock=0, digit_idx=0, refresh counter=0, tick_pending=0, state=IDLE
//   - Reset mid-transfer aborts immediately; lock never asserts on the reset cycle.
//  Refresh counter: free-running 0..REFRESH_DIV-1.
//   - tick = (cnt==REFRESH_DIV-1); a tick sets tick_pending.
//   - tick_pending is cleared on LOAD; a second tick while pending is dropped.
//  FSM:
//   - IDLE: if enable && tick_pending && !busy -> LOAD.
//   - LOAD: if digit_idx==0, snapshot digits/dp_mask/blank_mask, so each full scan is coherent.
//     Register data from the snapshot. -> STROBE.
//   - STROBE: lock=1 for exactly this cycle; data already stable. -> WAIT_HI.
//   - WAIT_HI: busy=1 -> WAIT_LO.
//     BUSY_TIMEOUT cycles without busy -> DONE (frame treated as lost, not resent).
//   - WAIT_LO: busy=0 -> DONE.
//   - DONE: digit_idx = (idx==NUM_DIGITS-1) ? 0 : idx+1. -> IDLE.
//  data is held constant from LOAD until the next LOAD; never changes while busy=1.
//  Segment rule:
//   - blank_mask[i] forces seg=0 (dp included).
//   - Otherwise seg = {dp_mask[i], hex7(nibble)}; invert if SEG_ACTIVE_LOW.
//  Digit rule: one-hot bit digit_idx, inverted if DIG_ACTIVE_LOW.
//  Latency: LOAD->lock = 1 cycle; tick->lock = 2 cycles when IDLE with busy low.
//  enable=0: the current transfer completes; no new LOAD; data keeps last frame.
//  busy already high in IDLE (external use) delays LOAD; tick_pending is kept.
//  Simultaneous tick and DONE: tick_pending is set, next LOAD follows directly.
// STRUCTURE
//  Shared package/header:
//   - FSM state encodings
//   - hex->7seg constant table (0..F, active-high {g..a})
//   - SEG_OFF/DIG_OFF helpers
//  Sub-module hex_to_seg7: combinational nibble -> 7-bit pattern.
//  Top holds counter, FSM, snapshot and frame registers.
// TESTING
//  1. rst=1 for 3 clk -> data=16'hFFFF, lock=0, digit_idx=0. No lock for REFRESH_DIV-1 cycles after release.
//  2. digits=32'h76543210, dp=0, blank=0, driver model (busy 40 cycles) ->
//     first frame data=16'hC0FE (digit0 "0"); then 16'hF9FD (digit1 "1"); idx wraps 7->0.
//  3. Change digits mid-scan at idx=3 -> digits 4..7 still show old values;
//     new value appears from idx=0.
//  4. blank_mask=8'h04, dp_mask=8'h04 -> digit2 frame segments=8'hFF; dp_mask ignored.
//  5. busy never rises -> lock once, return after BUSY_TIMEOUT, idx advances; no hang.
//  6. rst pulse while in WAIT_LO -> next cycle data=16'hFFFF, idx=0, lock stays 0.
//     Clean restart; check that data never changes while busy=1 (assertion).

Source files
------------

// File: rtl/seg7_scan_hc595_pkg.sv
// Shared types and constants for the 7-segment scanner feeding a 74HC595 driver.
package seg7_scan_hc595_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_STROBE,
    ST_WAIT_HI,
    ST_WAIT_LO,
    ST_DONE
  } state_t;

  // Active-high {g,f,e,d,c,b,a}; element 0 is the last entry of the concatenation.
  localparam logic [15:0][6:0] HEX7_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39,   // F E d C
    7'h7C, 7'h77, 7'h6F, 7'h7F,   // b A 9 8
    7'h07, 7'h7D, 7'h6D, 7'h66,   // 7 6 5 4
    7'h4F, 7'h5B, 7'h06, 7'h3F    // 3 2 1 0
  };

  function automatic logic [7:0] seg_off(input bit active_low);
    return active_low ? 8'hFF : 8'h00;
  endfunction

  function automatic logic [7:0] dig_off(input bit active_low);
    return active_low ? 8'hFF : 8'h00;
  endfunction

endpackage

// File: rtl/seg7_scan_hc595_hex_to_seg7.sv
// Combinational hex nibble to active-high 7-segment pattern {g..a}.
module hex_to_seg7
  import seg7_scan_hc595_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = HEX7_TABLE[nibble];

endmodule

// File: rtl/seg7_scan_hc595.sv
// Multiplexed 7-segment scanner: one 16-bit frame per refresh slot, handed to a
// 74HC595 serial driver with a single-cycle lock strobe and busy handshake.
module seg7_scan_hc595
  import seg7_scan_hc595_pkg::*;
#(
  parameter int NUM_DIGITS     = 8,
  parameter int REFRESH_DIV    = 50000,
  parameter int BUSY_TIMEOUT   = 16,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit DIG_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [31:0] digits,
  input  logic [7:0]  dp_mask,
  input  logic [7:0]  blank_mask,
  input  logic        busy,
  output logic [15:0] data,
  output logic        lock,
  output logic [2:0]  digit_idx
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int TO_W  = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [7:0] DIG_EN_MASK = 8'((1 << NUM_DIGITS) - 1);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic              tick;
  logic              tick_pending;
  logic [TO_W-1:0]   to_cnt;
  logic              timeout;
  logic              last_digit;

  logic [31:0]       snap_digits;
  logic [7:0]        snap_dp;
  logic [7:0]        snap_blank;

  logic [31:0]       src_digits;
  logic [7:0]        src_dp;
  logic [7:0]        src_blank;
  logic [3:0]        nibble;
  logic [6:0]        hex_seg;
  logic [7:0]        seg_raw;
  logic [7:0]        dig_raw;
  logic [15:0]       frame;

  assign tick       = (cnt == CNT_W'(REFRESH_DIV - 1));
  assign timeout    = (to_cnt == TO_W'(BUSY_TIMEOUT - 1));
  assign last_digit = (digit_idx == 3'(NUM_DIGITS - 1));

  always_ff @(posedge clk) begin
    if (rst)       cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + 1'b1;
  end

  // A tick that arrives while one is already pending is simply absorbed.
  always_ff @(posedge clk) begin
    if (rst)                    tick_pending <= 1'b0;
    else if (tick)              tick_pending <= 1'b1;
    else if (state == ST_LOAD)  tick_pending <= 1'b0;
  end

  // NOTE: sequential state uses <= so every flop samples pre-edge values;
  // combinational processes use = and are evaluated in order.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // NOTE: state_nxt is given a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:    if (enable && (tick_pending || tick) && !busy) state_nxt = ST_LOAD;
      ST_LOAD:    state_nxt = ST_STROBE;
      ST_STROBE:  state_nxt = ST_WAIT_HI;
      ST_WAIT_HI: if (busy)         state_nxt = ST_WAIT_LO;
                  else if (timeout) state_nxt = ST_DONE;
      ST_WAIT_LO: if (!busy)        state_nxt = ST_DONE;
      ST_DONE:    state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    lock = (state == ST_STROBE) && !rst;
  end

  always_ff @(posedge clk) begin
    if (rst)                      to_cnt <= '0;
    else if (state == ST_STROBE)  to_cnt <= '0;
    else if (state == ST_WAIT_HI) to_cnt <= to_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)                                  digit_idx <= '0;
    else if (state == ST_DONE && last_digit)  digit_idx <= '0;
    else if (state == ST_DONE)                digit_idx <= digit_idx + 1'b1;
  end

  // NOTE: the snapshot is a plain data store with no reset: after reset digit_idx
  // is 0, so the live inputs are used and the snapshot is written before it is read.
  always_ff @(posedge clk) begin
    if (state == ST_LOAD && digit_idx == 3'd0) begin
      snap_digits <= digits;
      snap_dp     <= dp_mask;
      snap_blank  <= blank_mask;
    end
  end

  // Digit 0 takes the live inputs (the same values being snapshotted this cycle),
  // so every scan is built from one coherent sample.
  always_comb begin
    src_digits = snap_digits;
    src_dp     = snap_dp;
    src_blank  = snap_blank;
    if (digit_idx == 3'd0) begin
      src_digits = digits;
      src_dp     = dp_mask;
      src_blank  = blank_mask;
    end
  end

  assign nibble = src_digits[{digit_idx, 2'b00} +: 4];

  hex_to_seg7 u_hex_to_seg7 (
    .nibble (nibble),
    .seg    (hex_seg)
  );

  always_comb begin
    seg_raw = src_blank[digit_idx] ? 8'h00 : {src_dp[digit_idx], hex_seg};
    dig_raw = (8'h01 << digit_idx) & DIG_EN_MASK;
    frame   = {SEG_ACTIVE_LOW ? ~seg_raw : seg_raw,
               DIG_ACTIVE_LOW ? ~dig_raw : dig_raw};
  end

  // The frame only changes on LOAD, which is entered with busy low.
  always_ff @(posedge clk) begin
    if (rst)                    data <= {seg_off(SEG_ACTIVE_LOW), dig_off(DIG_ACTIVE_LOW)};
    else if (state == ST_LOAD)  data <= frame;
  end

endmodule
